// File: rtl/bfly_prio_sched.sv
// Priority scheduler for a butterfly request/grant network.
// Produces one priority bit per router. The bits come from a round-robin
// counter or a 24-bit LFSR. When an input starves, the scheduler enters a
// BOOST phase that inverts the latched priorities for a bounded dwell.
// Optional feature: define BFLY_PRIO_SCHED_STATS_EN to count BOOST entries on
// boost_cnt_o. Without it, the output is tied to zero.
module bfly_prio_sched #(
   parameter int unsigned NumIn       = 8,
   parameter int unsigned StarveLimit = 15,
   parameter int unsigned BoostMax    = 4,
   parameter logic [23:0] LfsrSeed    = 24'hA5A5A5,
   localparam int unsigned Stages     = $clog2(NumIn),
   localparam int unsigned Routers    = NumIn / 2,
   localparam int unsigned PrioW      = Stages * Routers
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mode_i,
   input  logic [NumIn-1:0] req_i,
   input  logic [NumIn-1:0] gnt_i,
   output logic [PrioW-1:0] prio_o,
   output logic             boost_o,
   output logic [31:0]      boost_cnt_o
);

   localparam logic [23:0] SeedEff = (LfsrSeed == 24'd0) ? 24'h000001 : LfsrSeed;

   typedef enum logic [0:0] {StNormal, StBoost} state_e;

   state_e              state_q, state_d;
   logic [Stages-1:0]   cnt_q, cnt_d;
   logic [23:0]         lfsr_q, lfsr_d;
   logic [PrioW-1:0]    prio_q, prio_d;
   logic [Stages-1:0]   tgt_q, tgt_d;
   logic [3:0]          dwell_q, dwell_d;
   logic [7:0]          wait_q [NumIn];
   logic [7:0]          wait_d [NumIn];

   logic                hs;
   logic                advance;
   logic                starve;
   logic [Stages-1:0]   starve_idx;
   logic                boost_exit;
   logic [PrioW-1:0]    prio_normal;

   assign hs      = |(req_i & gnt_i);
   assign advance = hs && (state_q == StNormal);

   // Both priority sources step together so a mode switch never needs a resync.
   always_comb begin
      cnt_d  = cnt_q;
      lfsr_d = lfsr_q;
      if (advance) begin
         cnt_d  = cnt_q + 1'b1;
         lfsr_d = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
      end
   end

   // Router bit i belongs to stage i / Routers.
   for (genvar i = 0; i < int'(PrioW); i++) begin : g_prio
      assign prio_normal[i] = mode_i ? lfsr_q[i % 24] : cnt_q[i / Routers];
   end

   // Per-input wait counters; the boosted target is cleared on BOOST exit.
   for (genvar i = 0; i < int'(NumIn); i++) begin : g_wait
      assign wait_d[i] = (boost_exit && (tgt_q == Stages'(i))) ? 8'd0 :
                         (req_i[i] && !gnt_i[i]) ?
                         ((wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1) : 8'd0;
   end

   // Lowest-index starving input wins.
   always_comb begin
      starve     = 1'b0;
      starve_idx = '0;
      for (int i = int'(NumIn) - 1; i >= 0; i--) begin
         if (wait_q[i] >= 8'(StarveLimit)) begin
            starve     = 1'b1;
            starve_idx = Stages'(i);
         end
      end
   end

   // FSM next state. An exit always wins over a fresh starve.
   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      tgt_d      = tgt_q;
      dwell_d    = dwell_q;
      boost_exit = 1'b0;
      unique case (state_q)
         StNormal: begin
            if (starve) begin
               state_d = StBoost;
               prio_d  = prio_normal;
               tgt_d   = starve_idx;
               dwell_d = '0;
            end
         end
         StBoost: begin
            if (!req_i[tgt_q] || gnt_i[tgt_q] || (dwell_q == 4'(BoostMax - 1))) begin
               boost_exit = 1'b1;
               state_d    = StNormal;
            end else begin
               dwell_d = dwell_q + 4'd1;
            end
         end
         default: state_d = StNormal;
      endcase
   end

   // Core state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StNormal;
         cnt_q   <= '0;
         lfsr_q  <= SeedEff;
         prio_q  <= '0;
         tgt_q   <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         prio_q  <= prio_d;
         tgt_q   <= tgt_d;
         dwell_q <= dwell_d;
      end
   end

   // Wait counter registers.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(NumIn); i++) begin
         if (rst_i) begin
            wait_q[i] <= '0;
         end else begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign prio_o  = (state_q == StBoost) ? ~prio_q : prio_normal;
   assign boost_o = (state_q == StBoost);

`ifdef BFLY_PRIO_SCHED_STATS_EN
   logic [31:0] boost_cnt_q;

   // Count NORMAL->BOOST transitions, wrapping at 2^32.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         boost_cnt_q <= '0;
      end else if ((state_q == StNormal) && (state_d == StBoost)) begin
         boost_cnt_q <= boost_cnt_q + 32'd1;
      end
   end

   assign boost_cnt_o = boost_cnt_q;
`else
   assign boost_cnt_o = '0;
`endif

endmodule
